// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matrix-multiply operand loader.
// Holds the default element width and operand size, the element type, the
// loader state encoding and the operand buffer select values.
package matmul_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_M          = 32;
   typedef logic signed [DEF_DATA_WIDTH-1:0] element_t;
   typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_DONE, S_ERR} state_t;
   localparam logic BUF_A = 1'b0;
   localparam logic BUF_B = 1'b1;
endpackage

// File: rtl/mat_idx_counter.sv
// mat_idx_counter: row-major row/col index counter with runtime wrap limits.
// Ports: clk_i/reset_i clock and async active-high reset; clr_i forces (0,0);
// adv_i steps one element; rows_i/cols_i current limits; row_o/col_o index;
// last_o high while the index sits on the final element (rows-1, cols-1).
module mat_idx_counter #(
   parameter int DW = 6,
   parameter int IW = 5
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          clr_i,
   input  logic          adv_i,
   input  logic [DW-1:0] rows_i,
   input  logic [DW-1:0] cols_i,
   output logic [IW-1:0] row_o,
   output logic [IW-1:0] col_o,
   output logic          last_o
);
   logic [IW-1:0] row_q, row_d, col_q, col_d;
   logic          col_end;
   assign col_end = DW'(col_q) == cols_i - DW'(1);
   assign last_o  = col_end && (DW'(row_q) == rows_i - DW'(1));
   assign row_o   = row_q;
   assign col_o   = col_q;
   // Stepping past the last element wraps to (0,0) so the same counter can
   // start the next operand immediately with new limits.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr_i || (adv_i && last_o)) begin
         row_d = '0;
         col_d = '0;
      end else if (adv_i) begin
         col_d = col_end ? '0 : col_q + IW'(1);
         row_d = col_end ? row_q + IW'(1) : row_q;
      end
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end
endmodule

// File: rtl/mat_loader.sv
// mat_loader: streams a shape header then matrices A and B into operand buffers.
// Ports: clk_i/reset_i clock and async active-high reset; cfg_* header
// handshake with dims n (rows), m (cols), q (cols2); in_* element handshake;
// wr_* registered buffer write port (sel 0=A, 1=B); done_o/err_o one-cycle
// completion/rejection pulses; shape_*_o dims latched at the last header.
module mat_loader
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int M          = DEF_M,
   parameter int DW         = $clog2(M + 1),
   parameter int IW         = $clog2(M)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         cfg_valid_i,
   output logic                         cfg_ready_o,
   input  logic [DW-1:0]                cfg_rows_i,
   input  logic [DW-1:0]                cfg_cols_i,
   input  logic [DW-1:0]                cfg_cols2_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic signed [DATA_WIDTH-1:0] in_data_i,
   output logic                         wr_en_o,
   output logic                         wr_sel_o,
   output logic [IW-1:0]                wr_row_o,
   output logic [IW-1:0]                wr_col_o,
   output logic signed [DATA_WIDTH-1:0] wr_data_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [DW-1:0]                shape_n_o,
   output logic [DW-1:0]                shape_m_o,
   output logic [DW-1:0]                shape_q_o
);
   state_t                       state_q, state_d;
   logic [DW-1:0]                n_q, m_q, q_q;
   logic                         wr_en_q, wr_sel_q;
   logic [IW-1:0]                wr_row_q, wr_col_q;
   logic signed [DATA_WIDTH-1:0] wr_data_q;
   logic                         cfg_fire, in_fire, bad_dims, last;
   logic [IW-1:0]                row, col;
   logic [DW-1:0]                lim_rows, lim_cols;

   assign cfg_fire = cfg_valid_i && cfg_ready_o;
   assign in_fire  = in_valid_i && in_ready_o;
   assign bad_dims = (cfg_rows_i == '0) || (cfg_rows_i > DW'(M)) ||
                     (cfg_cols_i == '0) || (cfg_cols_i > DW'(M)) ||
                     (cfg_cols2_i == '0) || (cfg_cols2_i > DW'(M));
   // A is n x m, B is m x q; limits switch with the state so the counter
   // picks up B's shape on the cycle after A's last element.
   assign lim_rows = (state_q == S_LOAD_B) ? m_q : n_q;
   assign lim_cols = (state_q == S_LOAD_B) ? q_q : m_q;

   mat_idx_counter #(.DW(DW), .IW(IW)) u_idx (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (cfg_fire),
      .adv_i   (in_fire),
      .rows_i  (lim_rows),
      .cols_i  (lim_cols),
      .row_o   (row),
      .col_o   (col),
      .last_o  (last)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cfg_fire) state_d = bad_dims ? S_ERR : S_LOAD_A;
         S_LOAD_A: if (in_fire && last) state_d = S_LOAD_B;
         S_LOAD_B: if (in_fire && last) state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o = state_q == S_IDLE;
      in_ready_o  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
      done_o      = state_q == S_DONE;
      err_o       = state_q == S_ERR;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         n_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= BUF_A;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= in_fire;
         if (cfg_fire) begin
            n_q <= cfg_rows_i;
            m_q <= cfg_cols_i;
            q_q <= cfg_cols2_i;
         end
         if (in_fire) begin
            wr_sel_q  <= (state_q == S_LOAD_B) ? BUF_B : BUF_A;
            wr_row_q  <= row;
            wr_col_q  <= col;
            wr_data_q <= in_data_i;
         end
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_sel_o  = wr_sel_q;
   assign wr_row_o  = wr_row_q;
   assign wr_col_o  = wr_col_q;
   assign wr_data_o = wr_data_q;
   assign shape_n_o = n_q;
   assign shape_m_o = m_q;
   assign shape_q_o = q_q;
endmodule

// File: tb/tb_mat_loader.sv
// tb_mat_loader: self-checking bench for mat_loader with a write scoreboard.
module tb_mat_loader;
   localparam int DWD = 16;
   localparam int DW  = 6;
   localparam int IW  = 5;

   logic           clk = 1'b0, reset = 1'b1;
   logic           cfg_valid = 1'b0, in_valid = 1'b0;
   logic [DW-1:0]  cfg_rows = '0, cfg_cols = '0, cfg_cols2 = '0;
   logic [DWD-1:0] in_data = '0;
   logic           cfg_ready, in_ready, wr_en, wr_sel, done, err;
   logic [IW-1:0]  wr_row, wr_col;
   logic [DWD-1:0] wr_data;
   logic [DW-1:0]  shape_n, shape_m, shape_q;

   mat_loader dut (
      .clk_i(clk), .reset_i(reset),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
      .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols), .cfg_cols2_i(cfg_cols2),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .wr_en_o(wr_en), .wr_sel_o(wr_sel), .wr_row_o(wr_row), .wr_col_o(wr_col),
      .wr_data_o(wr_data), .done_o(done), .err_o(err),
      .shape_n_o(shape_n), .shape_m_o(shape_m), .shape_q_o(shape_q)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic           sel;
      logic [IW-1:0]  row;
      logic [IW-1:0]  col;
      logic [DWD-1:0] data;
   } wr_t;

   typedef struct {
      int n, m, q, gap;
      bit bad;
   } vec_t;

   wr_t exp_q[$];
   int  n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_t a, e;
         a = {wr_sel, wr_row, wr_col, wr_data};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL write: got unexpected %h want none at %0t", a, $time);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               n_bad++;
               $display("FAIL write: got %h want %h at %0t", a, e, $time);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "timeout");
   end

   task automatic header(input int n, input int m, input int q);
      int k = 0;
      @(negedge clk);
      while (cfg_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("cfg_ready_wait", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_rows  = DW'(n);
      cfg_cols  = DW'(m);
      cfg_cols2 = DW'(q);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic check_err();
      chk("err_pulse", err, 1);
      chk("err_in_ready", in_ready, 0);
      chk("err_done", done, 0);
      @(negedge clk);
      chk("err_cfg_ready", cfg_ready, 1);
      chk("err_clear", err, 0);
   endtask

   task automatic put(input logic sel, input int r, input int c, input logic [DWD-1:0] d, input int gap);
      while ($urandom_range(99) < gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      chk("in_ready", in_ready, 1);
      exp_q.push_back({sel, IW'(r), IW'(c), d});
      @(negedge clk);
   endtask

   task automatic stream(input int n, input int m, input int q, input int gap, input int base);
      int v = base;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < m; c++) put(1'b0, r, c, DWD'(v++), gap);
      for (int r = 0; r < m; r++)
         for (int c = 0; c < q; c++) put(1'b1, r, c, DWD'(v++), gap);
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      chk("done_pulse", done, 1);
      chk("shape_n", shape_n, n);
      chk("shape_m", shape_m, m);
      chk("shape_q", shape_q, q);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("idle_cfg_ready", cfg_ready, 1);
   endtask

   initial begin
      vec_t tbl[7];
      tbl[0] = '{n: 2,  m: 2,  q: 2,  gap: 0,  bad: 0};
      tbl[1] = '{n: 32, m: 16, q: 32, gap: 40, bad: 0};
      tbl[2] = '{n: 0,  m: 0,  q: 0,  gap: 0,  bad: 1};
      tbl[3] = '{n: 33, m: 32, q: 32, gap: 0,  bad: 1};
      tbl[4] = '{n: 3,  m: 5,  q: 2,  gap: 30, bad: 0};
      tbl[5] = '{n: 32, m: 32, q: 1,  gap: 0,  bad: 0};
      tbl[6] = '{n: 4,  m: 0,  q: 4,  gap: 0,  bad: 1};

      #12;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_shape", {shape_n, shape_m, shape_q}, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         header(tbl[i].n, tbl[i].m, tbl[i].q);
         if (tbl[i].bad) check_err();
         else stream(tbl[i].n, tbl[i].m, tbl[i].q, tbl[i].gap, 1);
      end

      // 1x1x1 with signed data: done exactly three cycles after the header
      header(1, 1, 1);
      put(1'b0, 0, 0, 16'hFFFD, 0);
      put(1'b1, 0, 0, 16'h0007, 0);
      in_valid = 1'b0;
      chk("unit_done", done, 1);
      @(negedge clk);
      chk("unit_idle", cfg_ready, 1);

      // asynchronous reset in the middle of loading A
      header(4, 4, 4);
      for (int k = 0; k < 5; k++) put(1'b0, k / 4, k % 4, DWD'(100 + k), 0);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_cfg_ready", cfg_ready, 1);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_wr_en", wr_en, 0);
      chk("arst_wr_pos", {wr_sel, wr_row, wr_col, wr_data}, 0);
      chk("arst_done", done, 0);
      chk("arst_shape", {shape_n, shape_m, shape_q}, 0);
      @(negedge clk);
      chk("arst_no_done", done, 0);
      reset = 1'b0;
      header(2, 2, 2);
      stream(2, 2, 2, 0, 300);

      // header held valid during a load is ignored
      header(2, 3, 2);
      cfg_valid = 1'b1;
      cfg_rows  = 6'd5;
      cfg_cols  = 6'd5;
      cfg_cols2 = 6'd5;
      chk("busy_cfg_ready", cfg_ready, 0);
      stream(2, 3, 2, 20, 500);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
